// File: rtl/controlador_senha_comparador.sv
// Password sequencer: feeds entered/stored octal digits to an external 3-bit equality
// comparator, tracks failed attempts and enforces a timed lockout.
module controlador_senha_comparador #(
  parameter int unsigned               N_DIGITS    = 4,
  parameter logic [3*N_DIGITS-1:0]     SENHA       = 12'o7531,
  parameter int unsigned               MAX_TRIES   = 3,
  parameter int unsigned               LOCK_CYCLES = 16
) (
  input  logic                               CLK,
  input  logic                               RST,
  input  logic                               DIG_VALID,
  input  logic [2:0]                         DIG,
  output logic                               DIG_READY,
  input  logic                               CLEAR,
  output logic [2:0]                         CMP_X,
  output logic [2:0]                         CMP_Y,
  input  logic                               CMP_EQ,
  output logic                               UNLOCK,
  output logic                               FAIL,
  output logic                               LOCKED,
  output logic [$clog2(MAX_TRIES+1)-1:0]     TRIES
);

  localparam int unsigned TRIES_W = $clog2(MAX_TRIES + 1);
  localparam int unsigned IDX_W   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int unsigned TMR_W   = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_ENTRY,
    ST_CHECK,
    ST_OPEN,
    ST_BLOCK
  } state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 mis_q, mis_d;
  logic [TRIES_W-1:0]   tries_q, tries_d;
  logic [TMR_W-1:0]     timer_q, timer_d;
  logic [2:0]           cmp_x_q, cmp_x_d;
  logic [2:0]           cmp_y_q, cmp_y_d;
  logic                 unlock_q, unlock_d;
  logic                 fail_q, fail_d;
  logic                 locked_q, locked_d;

  logic [3*N_DIGITS-1:0] senha_shift;
  logic [2:0]            senha_dig;
  logic                  mis_n;
  logic                  xfer;
  logic [TRIES_W-1:0]    tries_inc;

  // CLEAR wins over DIG_VALID, hence the combinational path from CLEAR.
  assign DIG_READY = (state_q == ST_ENTRY) && !CLEAR && !RST;
  assign xfer      = DIG_VALID && DIG_READY;

  always_comb begin
    senha_shift = SENHA >> (3 * 32'(idx_q));
    senha_dig   = senha_shift[2:0];
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    mis_d     = mis_q;
    tries_d   = tries_q;
    timer_d   = timer_q;
    cmp_x_d   = cmp_x_q;
    cmp_y_d   = cmp_y_q;
    fail_d    = 1'b0;
    mis_n     = mis_q | !CMP_EQ;
    tries_inc = tries_q + TRIES_W'(1);

    case (state_q)
      ST_ENTRY: begin
        if (xfer) begin
          cmp_x_d = DIG;
          cmp_y_d = senha_dig;
          state_d = ST_CHECK;
        end else if (CLEAR) begin
          idx_d = '0;
          mis_d = 1'b0;
        end
      end
      ST_CHECK: begin
        // All digits are consumed before judging, so a wrong digit leaks no timing.
        if (idx_q != IDX_W'(N_DIGITS - 1)) begin
          idx_d   = idx_q + IDX_W'(1);
          mis_d   = mis_n;
          state_d = ST_ENTRY;
        end else begin
          idx_d = '0;
          mis_d = 1'b0;
          if (!mis_n) begin
            tries_d = '0;
            state_d = ST_OPEN;
          end else begin
            fail_d = 1'b1;
            if (tries_inc == TRIES_W'(MAX_TRIES)) begin
              tries_d = TRIES_W'(MAX_TRIES);
              timer_d = TMR_W'(LOCK_CYCLES - 1);
              state_d = ST_BLOCK;
            end else begin
              tries_d = tries_inc;
              state_d = ST_ENTRY;
            end
          end
        end
      end
      ST_OPEN: begin
        if (CLEAR) state_d = ST_ENTRY;
      end
      ST_BLOCK: begin
        if (timer_q == '0) begin
          tries_d = '0;
          state_d = ST_ENTRY;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      default: state_d = ST_ENTRY;
    endcase

    unlock_d = (state_d == ST_OPEN);
    locked_d = (state_d == ST_BLOCK);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ST_ENTRY;
      idx_q    <= '0;
      mis_q    <= 1'b0;
      tries_q  <= '0;
      timer_q  <= '0;
      cmp_x_q  <= '0;
      cmp_y_q  <= '0;
      unlock_q <= 1'b0;
      fail_q   <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      mis_q    <= mis_d;
      tries_q  <= tries_d;
      timer_q  <= timer_d;
      cmp_x_q  <= cmp_x_d;
      cmp_y_q  <= cmp_y_d;
      unlock_q <= unlock_d;
      fail_q   <= fail_d;
      locked_q <= locked_d;
    end
  end

  assign CMP_X  = cmp_x_q;
  assign CMP_Y  = cmp_y_q;
  assign UNLOCK = unlock_q;
  assign FAIL   = fail_q;
  assign LOCKED = locked_q;
  assign TRIES  = tries_q;

endmodule
